// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD digit limits for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] SEC_U_MAX = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] MIN_U_MAX = 4'd9;
    localparam logic [3:0] MIN_T_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_timekeeper_sync.sv
// rtl/stopwatch_timekeeper_sync.sv - level synchroniser with registered rising-edge pulse
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Pulse is registered so an input edge appears SYNC_STAGES+1 cycles later.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/stopwatch_timekeeper.sv
// rtl/stopwatch_timekeeper.sv - BCD MM:SS stopwatch with start/pause, clear and lap hold
module stopwatch_timekeeper
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       rstn,
    input  logic       TICK_IN,
    input  logic       BTN_SS,
    input  logic       BTN_CLR,
    input  logic       BTN_LAP,
    output logic [3:0] SEC_U,
    output logic [3:0] SEC_T,
    output logic [3:0] MIN_U,
    output logic [3:0] MIN_T,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       WRAP
);

    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    logic       tick_p, ss_p, clr_p, lap_p;
    state_t     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic       inc;
    logic [3:0] live_su, live_st, live_mu, live_mt;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_tick (.clk(CLK), .rstn(rstn), .din(TICK_IN), .pulse(tick_p));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ss   (.clk(CLK), .rstn(rstn), .din(BTN_SS),  .pulse(ss_p));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clr  (.clk(CLK), .rstn(rstn), .din(BTN_CLR), .pulse(clr_p));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lap  (.clk(CLK), .rstn(rstn), .din(BTN_LAP), .pulse(lap_p));

    always_ff @(posedge CLK) begin
        if (!rstn) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    // Clear outranks start/stop in every state.
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = IDLE;
        end else if (ss_p) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        inc     = (state_q == RUN) && tick_p && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (clr_p || state_q == IDLE) begin
            presc_d = '0;
        end else if (state_q == RUN && tick_p) begin
            presc_d = inc ? 8'd0 : presc_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rstn || clr_p) begin
            live_su <= '0;
            live_st <= '0;
            live_mu <= '0;
            live_mt <= '0;
            WRAP    <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            if (inc) begin
                if (live_su == SEC_U_MAX) begin
                    live_su <= '0;
                    if (live_st == SEC_T_MAX) begin
                        live_st <= '0;
                        if (live_mu == MIN_U_MAX) begin
                            live_mu <= '0;
                            if (live_mt == MIN_T_MAX) begin
                                live_mt <= '0;
                                WRAP    <= 1'b1;
                            end else begin
                                live_mt <= live_mt + 4'd1;
                            end
                        end else begin
                            live_mu <= live_mu + 4'd1;
                        end
                    end else begin
                        live_st <= live_st + 4'd1;
                    end
                end else begin
                    live_su <= live_su + 4'd1;
                end
            end
        end
    end

    // Display lags the live count by one cycle and freezes while a lap is held.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            SEC_U      <= '0;
            SEC_T      <= '0;
            MIN_U      <= '0;
            MIN_T      <= '0;
            RUNNING    <= 1'b0;
            LAP_ACTIVE <= 1'b0;
        end else begin
            RUNNING <= (state_d == RUN);
            if (state_d == IDLE) begin
                LAP_ACTIVE <= 1'b0;
            end else if (lap_p && state_q != IDLE) begin
                LAP_ACTIVE <= ~LAP_ACTIVE;
            end
            if (!LAP_ACTIVE) begin
                SEC_U <= live_su;
                SEC_T <= live_st;
                MIN_U <= live_mu;
                MIN_T <= live_mt;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// tb/tb_stopwatch_timekeeper.sv - directed self-checking bench for stopwatch_timekeeper
module tb_stopwatch_timekeeper;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick_in = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;

    logic [3:0] su1, st1, mu1, mt1, su4, st4, mu4, mt4;
    logic       run1, lap1, wrap1, run4, lap4, wrap4;

    int checks = 0;
    int errors = 0;
    int wrap_cycles;

    always #5 clk = ~clk;

    stopwatch_timekeeper #(.TICK_DIV(1), .SYNC_STAGES(2)) dut (
        .CLK(clk), .rstn(rstn), .TICK_IN(tick_in), .BTN_SS(btn_ss), .BTN_CLR(btn_clr), .BTN_LAP(btn_lap),
        .SEC_U(su1), .SEC_T(st1), .MIN_U(mu1), .MIN_T(mt1),
        .RUNNING(run1), .LAP_ACTIVE(lap1), .WRAP(wrap1)
    );

    stopwatch_timekeeper #(.TICK_DIV(4), .SYNC_STAGES(2)) dut4 (
        .CLK(clk), .rstn(rstn), .TICK_IN(tick_in), .BTN_SS(btn_ss), .BTN_CLR(btn_clr), .BTN_LAP(btn_lap),
        .SEC_U(su4), .SEC_T(st4), .MIN_U(mu4), .MIN_T(mt4),
        .RUNNING(run4), .LAP_ACTIVE(lap4), .WRAP(wrap4)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc(2);
            tick_in = 1'b0;
            cyc(2);
        end
        cyc(6);
    endtask

    task automatic press(input int which, input logic both);
        if (which == 0 || both) btn_ss = 1'b1;
        if (which == 1 || both) btn_clr = 1'b1;
        if (which == 2) btn_lap = 1'b1;
        cyc(2);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        cyc(8);
    endtask

    function automatic logic [31:0] disp1();
        return {16'h0, mt1, mu1, st1, su1};
    endfunction

    function automatic logic [31:0] disp4();
        return {16'h0, mt4, mu4, st4, su4};
    endfunction

    initial begin
        cyc(3);
        check("reset_disp", disp1(), 32'h0000);
        check("reset_flags", {29'h0, run1, lap1, wrap1}, 32'h0);
        rstn = 1'b1;
        cyc(2);

        press(0, 1'b0);
        check("start_running", {31'h0, run1}, 32'h1);
        ticks(75);
        check("start_0115", disp1(), 32'h0115);

        press(1, 1'b0);
        check("clr_disp", disp1(), 32'h0000);
        check("clr_running", {31'h0, run1}, 32'h0);
        press(0, 1'b0);
        ticks(10);
        check("pause_pre_0010", disp1(), 32'h0010);
        press(0, 1'b0);
        check("pause_running", {31'h0, run1}, 32'h0);
        ticks(20);
        check("pause_hold_0010", disp1(), 32'h0010);
        press(0, 1'b0);
        check("resume_running", {31'h0, run1}, 32'h1);
        ticks(5);
        check("resume_0015", disp1(), 32'h0015);

        press(1, 1'b0);
        press(0, 1'b0);
        ticks(3599);
        check("wrap_pre_5959", disp1(), 32'h5959);
        wrap_cycles = 0;
        tick_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (i == 1) tick_in = 1'b0;
            if (wrap1) wrap_cycles++;
        end
        check("wrap_pulse_count", wrap_cycles, 32'd1);
        check("wrap_0000", disp1(), 32'h0000);
        check("wrap_running", {31'h0, run1}, 32'h1);

        press(1, 1'b0);
        press(0, 1'b0);
        ticks(7);
        check("lap_pre_0007", disp1(), 32'h0007);
        press(2, 1'b0);
        check("lap_active_set", {31'h0, lap1}, 32'h1);
        ticks(5);
        check("lap_hold_0007", disp1(), 32'h0007);
        press(2, 1'b0);
        check("lap_active_clr", {31'h0, lap1}, 32'h0);
        check("lap_release_0012", disp1(), 32'h0012);

        press(1, 1'b0);
        press(0, 1'b0);
        ticks(150);
        check("prio_pre_0230", disp1(), 32'h0230);
        press(2, 1'b0);
        check("prio_lap_set", {31'h0, lap1}, 32'h1);
        press(0, 1'b1);
        check("prio_disp", disp1(), 32'h0000);
        check("prio_running", {31'h0, run1}, 32'h0);
        check("prio_lap", {31'h0, lap1}, 32'h0);
        ticks(3);
        check("prio_idle_no_count", disp1(), 32'h0000);

        press(0, 1'b0);
        ticks(10);
        check("presc_div4_0002", disp4(), 32'h0002);
        check("presc_div1_0010", disp1(), 32'h0010);
        check("presc_running", {31'h0, run4}, 32'h1);
        rstn = 1'b0;
        cyc(1);
        check("midreset_disp", disp4(), 32'h0000);
        check("midreset_flags", {29'h0, run4, lap4, wrap4}, 32'h0);
        check("midreset_disp1", disp1(), 32'h0000);
        rstn = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
